ulaw_codec_pipe: RTL

//  Parametrised, pipelined G.711 u-law codec; successor to the single-mode 8->14-bit expander.
//  Per-transfer mode selects expand (8-bit code -> linear) or compress (linear -> 8-bit code).

---
 rtl/ulaw_codec_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/ulaw_codec_pipe.sv
// ulaw_codec_pipe: two-stage elastic G.711 u-law codec. Each sample carries its own mode
// (0 = expand code->linear, 1 = compress linear->code) and channel tag.
// S1 registers sign/segment/mantissa for both modes; S2 registers the finished result.
// Optional feature: define ULAW_CLIP_CNT_EN to build the saturating compress clip counter;
// without it clip_cnt is tied to zero and the datapath is unchanged.
module ulaw_codec_pipe #(
  parameter int LIN_W = 14,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [LIN_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [CH_W-1:0]  out_ch,
  output logic [LIN_W-1:0] out_data,
  output logic [15:0]      clip_cnt
);

  localparam int          SH      = LIN_W - 14;
  localparam logic [14:0] MAG_MAX = 15'd8158;

  // Magnitude of the 14-bit core sample; one extra bit so -8192 maps to +8192.
  function automatic logic [14:0] abs_lin(input logic [LIN_W-1:0] d);
    logic signed [LIN_W:0] xs;
    logic signed [LIN_W:0] xa;
    xs = signed'({d[LIN_W-1], d}) >>> SH;
    xa = xs[LIN_W] ? -xs : xs;
    return xa[14:0];
  endfunction

  // Clamp the compress magnitude to the largest value the code space can represent.
  function automatic logic [14:0] sat_mag(input logic [14:0] mag);
    return (mag > MAG_MAX) ? MAG_MAX : mag;
  endfunction

  // Segment = position of the leading one of the biased magnitude, minus 5.
  function automatic logic [2:0] seg_of(input logic [12:0] b);
    logic [2:0] seg;
    seg = 3'd0;
    for (int i = 0; i <= 12; i++) begin
      if (i >= 5 && b[i]) seg = 3'(i - 5);
    end
    return seg;
  endfunction

  // Decoded code back to signed linear, scaled up to the I/O width.
  function automatic logic signed [LIN_W-1:0] expand_lin(input logic s, input logic [2:0] seg,
                                                         input logic [3:0] m);
    logic [13:0]             mag;
    logic signed [13:0]      lin14;
    logic signed [LIN_W-1:0] ext;
    mag   = ((14'({m, 1'b0}) + 14'd33) << seg) - 14'd33;
    lin14 = s ? -signed'(mag) : signed'(mag);
    ext   = LIN_W'(lin14);
    return ext <<< SH;
  endfunction

`ifdef ULAW_CLIP_CNT_EN
  // Saturating increment for the clip counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic             vld_p1_q, vld_p1_d;
  logic             mode_p1_q, mode_p1_d;
  logic [CH_W-1:0]  ch_p1_q, ch_p1_d;
  logic             sign_p1_q, sign_p1_d;
  logic [2:0]       seg_p1_q, seg_p1_d;
  logic [3:0]       mant_p1_q, mant_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic             mode_p2_q, mode_p2_d;
  logic [CH_W-1:0]  ch_p2_q, ch_p2_d;
  logic [LIN_W-1:0] data_p2_q, data_p2_d;

  logic             s1_take, s2_take;
  logic [14:0]      f_mag;
  logic [12:0]      f_b;
  logic             f_sign;
  logic [2:0]       f_seg;
  logic [3:0]       f_mant;
  logic [LIN_W-1:0] lin_res;
  logic [LIN_W-1:0] code_res;

  // Input decode: both modes reduce to sign/segment/mantissa before S1.
  always_comb begin
    f_mag = abs_lin(in_data);
    f_b   = 13'(sat_mag(f_mag) + 15'd33);
    if (in_mode) begin
      f_sign = in_data[LIN_W-1];
      f_seg  = seg_of(f_b);
      f_mant = f_b[{1'b0, f_seg} + 4'd1 +: 4];
    end else begin
      f_sign = in_data[7];
      f_seg  = in_data[6:4];
      f_mant = in_data[3:0];
    end
  end

  // Handshake and stage advance: a stage loads when its successor is empty or draining.
  always_comb begin
    s2_take   = !vld_p2_q || out_ready;
    s1_take   = !vld_p1_q || s2_take;

    vld_p1_d  = vld_p1_q;
    mode_p1_d = mode_p1_q;
    ch_p1_d   = ch_p1_q;
    sign_p1_d = sign_p1_q;
    seg_p1_d  = seg_p1_q;
    mant_p1_d = mant_p1_q;
    if (s1_take) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        mode_p1_d = in_mode;
        ch_p1_d   = in_ch;
        sign_p1_d = f_sign;
        seg_p1_d  = f_seg;
        mant_p1_d = f_mant;
      end
    end

    lin_res  = expand_lin(sign_p1_q, seg_p1_q, mant_p1_q);
    code_res = LIN_W'({sign_p1_q, seg_p1_q, mant_p1_q});

    vld_p2_d  = vld_p2_q;
    mode_p2_d = mode_p2_q;
    ch_p2_d   = ch_p2_q;
    data_p2_d = data_p2_q;
    if (s2_take) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        mode_p2_d = mode_p1_q;
        ch_p2_d   = ch_p1_q;
        data_p2_d = mode_p1_q ? code_res : lin_res;
      end
    end
  end

  // Stage boundaries S1 -> S2 -> output; outputs return to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      mode_p1_q <= 1'b0;
      ch_p1_q   <= '0;
      sign_p1_q <= 1'b0;
      seg_p1_q  <= 3'd0;
      mant_p1_q <= 4'd0;
      vld_p2_q  <= 1'b0;
      mode_p2_q <= 1'b0;
      ch_p2_q   <= '0;
      data_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      mode_p1_q <= mode_p1_d;
      ch_p1_q   <= ch_p1_d;
      sign_p1_q <= sign_p1_d;
      seg_p1_q  <= seg_p1_d;
      mant_p1_q <= mant_p1_d;
      vld_p2_q  <= vld_p2_d;
      mode_p2_q <= mode_p2_d;
      ch_p2_q   <= ch_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  assign in_ready  = s1_take;
  assign out_valid = vld_p2_q;
  assign out_mode  = mode_p2_q;
  assign out_ch    = ch_p2_q;
  assign out_data  = data_p2_q;

`ifdef ULAW_CLIP_CNT_EN
  logic        f_clip;
  logic [15:0] clip_cnt_q, clip_cnt_d;

  // Count clipped compress samples as they are accepted at the input.
  always_comb begin
    f_clip     = in_mode && (f_mag > MAG_MAX);
    clip_cnt_d = clip_cnt_q;
    if (in_valid && s1_take && f_clip) clip_cnt_d = sat_inc(clip_cnt_q);
  end

  // Clip counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clip_cnt_q <= 16'h0000;
    else     clip_cnt_q <= clip_cnt_d;
  end

  assign clip_cnt = clip_cnt_q;
`else
  assign clip_cnt = 16'h0000;
`endif

endmodule
